// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM state codes,
// geometry constants, column one-hot decode and key-code construction.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int NROWS = 4;
  localparam int NCOLS = 4;

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] PRESS    = 2'd2;
  localparam logic [1:0] HOLD     = 2'd3;

  function automatic logic [NCOLS-1:0] col_onehot(input logic [1:0] idx);
    logic [NCOLS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // row_pat is one-hot by construction; code = row_idx*4 + col_idx
  function automatic logic [KEY_W-1:0] key_code(input logic [NROWS-1:0] row_pat,
                                                input logic [1:0]       col_idx);
    logic [1:0] row_idx;
    row_idx = '0;
    for (int r = 0; r < NROWS; r++) begin
      if (row_pat[r]) row_idx = 2'(r);
    end
    return {row_idx, col_idx};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, synchronous
// active-high reset clears both stages.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments make both stages sample pre-edge values;
  // blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan sequencer: column strobing, row debounce, valid/ready key
// delivery. Define KEYPAD_REPEAT_EN to enable auto-repeat while a key is held.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE_CNT  = 16,
  parameter int REPEAT_DELAY  = 2000,
  parameter int REPEAT_RATE   = 500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_en,
  input  logic [NROWS-1:0] rows,
  output logic [NCOLS-1:0] cols,
  output logic [1:0]       counter_cols,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             overflow,
  output logic             busy
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CNT - 1);

  logic [NROWS-1:0] rows_s;

  logic [1:0]       state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [DW-1:0]    deb_q, deb_d;
  logic [DW-1:0]    rel_q, rel_d;
  logic [NROWS-1:0] cap_q, cap_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             overflow_q, overflow_d;
  logic             issue;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] rep_q, rep_d;
  logic          armed_q, armed_d;
`else
  logic unused_repeat_params;
  assign unused_repeat_params = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
`endif

  sync_2ff #(.WIDTH(NROWS)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rows),
    .q_o   (rows_s)
  );

  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    settle_d = settle_q;
    deb_d    = deb_q;
    rel_d    = rel_q;
    cap_d    = cap_q;
    issue    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d    = rep_q;
    armed_d  = armed_q;
`endif

    if (!scan_en) begin
      state_d  = SCAN;
      settle_d = '0;
      deb_d    = '0;
      rel_d    = '0;
`ifdef KEYPAD_REPEAT_EN
      rep_d    = '0;
      armed_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        SCAN: begin
          if (settle_q == SETTLE_LAST) begin
            settle_d = '0;
            // Ghosts and chords (several rows at once) are treated as no key
            if ($onehot(rows_s)) begin
              cap_d   = rows_s;
              deb_d   = '0;
              state_d = DEBOUNCE;
            end else begin
              col_d = col_q + 2'd1;
            end
          end else begin
            settle_d = settle_q + SW'(1);
          end
        end

        DEBOUNCE: begin
          if (rows_s == cap_q) begin
            if (deb_q == DEB_LAST) begin
              deb_d   = '0;
              state_d = PRESS;
            end else begin
              deb_d = deb_q + DW'(1);
            end
          end else begin
            deb_d    = '0;
            settle_d = '0;
            state_d  = SCAN;
          end
        end

        PRESS: begin
          issue   = 1'b1;
          rel_d   = '0;
          state_d = HOLD;
`ifdef KEYPAD_REPEAT_EN
          rep_d   = '0;
          armed_d = 1'b0;
`endif
        end

        default: begin  // HOLD
          if (rows_s == '0) begin
            if (rel_q == DEB_LAST) begin
              rel_d    = '0;
              settle_d = '0;
              col_d    = col_q + 2'd1;
              state_d  = SCAN;
            end else begin
              rel_d = rel_q + DW'(1);
            end
          end else begin
            rel_d = '0;
          end
`ifdef KEYPAD_REPEAT_EN
          if (rows_s == cap_q) begin
            if (rep_q == (armed_q ? RATE_LAST : DELAY_LAST)) begin
              rep_d   = '0;
              armed_d = 1'b1;
              issue   = 1'b1;
            end else begin
              rep_d = rep_q + RW'(1);
            end
          end else begin
            rep_d   = '0;
            armed_d = 1'b0;
          end
`endif
        end
      endcase
    end
  end

  // Handshake: a fresh code may replace one being consumed in the same cycle
  always_comb begin
    key_d       = key_q;
    key_valid_d = key_valid_q;
    overflow_d  = overflow_q;
    if (key_valid_q && key_ready) key_valid_d = 1'b0;
    if (issue) begin
      if (!key_valid_q || key_ready) begin
        key_d       = key_code(cap_q, col_q);
        key_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      col_q       <= '0;
      settle_q    <= '0;
      deb_q       <= '0;
      rel_q       <= '0;
      cap_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
      armed_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      settle_q    <= settle_d;
      deb_q       <= deb_d;
      rel_q       <= rel_d;
      cap_q       <= cap_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      overflow_q  <= overflow_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
      armed_q     <= armed_d;
`endif
    end
  end

  assign cols         = scan_en ? col_onehot(col_q) : '0;
  assign counter_cols = col_q;
  assign key          = key_q;
  assign key_valid    = key_valid_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != SCAN);

endmodule
